// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for the audio cores.
//   demod_state_e  - demodulator FSM states
//   SAMPLE_MAX/MIN - clamp limits for the default 16-bit sample width
//   sat_to_width() - clamp a wide signed value to a signed width of 'bits'
package audio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DCB,
    ST_RECT,
    ST_FILT,
    ST_OFFS,
    ST_SCALE
  } demod_state_e;

  localparam int AUDIO_BITSIZE = 16;
  localparam logic signed [AUDIO_BITSIZE-1:0] SAMPLE_MAX = {1'b0, {(AUDIO_BITSIZE-1){1'b1}}};
  localparam logic signed [AUDIO_BITSIZE-1:0] SAMPLE_MIN = {1'b1, {(AUDIO_BITSIZE-1){1'b0}}};

  // Clamp x to [-2^(bits-1), 2^(bits-1)-1]; the caller truncates to 'bits'.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] x,
                                                       input int bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bits - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/am_demodulator_if.sv
// am_demodulator_if: frame/sample bus of the AM demodulator.
//   lrclk   - frame strobe (rising edge starts a frame)
//   in      - modulated sample, signed
//   b       - modulation offset to remove, signed
//   gain    - output gain, signed Q1.(BITSIZE-1)
//   out     - demodulated sample, signed, held between valid pulses
//   valid   - one-cycle pulse when out updates
//   overrun - one-cycle pulse when a frame start is dropped
// master drives the frame inputs; slave is the demodulator.
interface am_demodulator_if #(
  parameter int BITSIZE = 16
);
  logic                      lrclk;
  logic signed [BITSIZE-1:0] in;
  logic signed [BITSIZE-1:0] b;
  logic signed [BITSIZE-1:0] gain;
  logic signed [BITSIZE-1:0] out;
  logic                      valid;
  logic                      overrun;

  modport master (output lrclk, in, b, gain, input out, valid, overrun);
  modport slave  (input lrclk, in, b, gain, output out, valid, overrun);
endinterface

// File: rtl/demod_onepole.sv
// demod_onepole: one-pole IIR, y <- y + ((x - y) >>> SHIFT).
//   bclk   - clock, rising edge
//   resetn - asynchronous active-low reset (y = 0)
//   en     - update strobe
//   x      - filter input, signed
//   y      - filter state, signed
// The step is formed in BITSIZE+1 bits; the new y always lies between the
// old y and x, so storing it back in BITSIZE bits cannot wrap.
module demod_onepole #(
  parameter int BITSIZE = 16,
  parameter int SHIFT   = 4
) (
  input  logic                      bclk,
  input  logic                      resetn,
  input  logic                      en,
  input  logic signed [BITSIZE-1:0] x,
  output logic signed [BITSIZE-1:0] y
);

  logic signed [BITSIZE:0] diff;
  logic signed [BITSIZE:0] step;
  logic signed [BITSIZE:0] sum;

  always_comb begin
    diff = (BITSIZE+1)'(x) - (BITSIZE+1)'(y);
    step = diff >>> SHIFT;
    sum  = (BITSIZE+1)'(y) + step;
  end

  // NOTE: sequential state is written with <= so every register samples the
  // values from before the clock edge, independent of statement order.
  always_ff @(posedge bclk or negedge resetn) begin
    if (!resetn) y <= '0;
    else if (en) y <= BITSIZE'(sum);
  end

endmodule

// File: rtl/am_demodulator.sv
// am_demodulator: envelope-detecting AM demodulator on the I2S bit clock.
//   bclk   - sole clock, rising edge
//   resetn - asynchronous active-low reset
//   bus    - am_demodulator_if.slave (lrclk, in, b, gain -> out, valid, overrun)
// Per frame: capture -> [DC block] -> rectify -> one-pole low-pass ->
// remove offset b -> scale by gain. valid pulses 5 bclk after the edge that
// first sees lrclk high (6 with the DC block).
// Optional feature: define AM_DEMODULATOR_DCBLOCK_EN to insert a DC-tracking
// stage (state DCB) that subtracts a running mean from the captured sample.
module am_demodulator
  import audio_pkg::*;
#(
  parameter int BITSIZE = 16,
  parameter int SHIFT   = 4
) (
  input  logic            bclk,
  input  logic            resetn,
  am_demodulator_if.slave bus
);

  demod_state_e state, state_nxt;

  logic                        lr_q;
  logic                        primed;
  logic                        frame_start;
  logic signed [BITSIZE-1:0]   in_q, b_q, gain_q;
  logic signed [BITSIZE-1:0]   r_q, d_q;
  logic signed [BITSIZE-1:0]   out_q;
  logic                        valid_q, overrun_q;
  logic signed [BITSIZE-1:0]   env_y;
  logic signed [BITSIZE-1:0]   rect, offs, scaled;
  logic signed [2*BITSIZE-1:0] prod;

  // The first edge after reset only samples lrclk, so a strobe already high
  // when reset releases is not mistaken for a frame start.
  assign frame_start = primed & bus.lrclk & ~lr_q;

  demod_onepole #(.BITSIZE(BITSIZE), .SHIFT(SHIFT)) u_env (
    .bclk   (bclk),
    .resetn (resetn),
    .en     (state == ST_FILT),
    .x      (r_q),
    .y      (env_y)
  );

`ifdef AM_DEMODULATOR_DCBLOCK_EN
  logic signed [BITSIZE-1:0] dc_y;
  logic signed [BITSIZE-1:0] dcb_sample;

  demod_onepole #(.BITSIZE(BITSIZE), .SHIFT(SHIFT)) u_dc (
    .bclk   (bclk),
    .resetn (resetn),
    .en     (state == ST_DCB),
    .x      (in_q),
    .y      (dc_y)
  );

  // The mean estimate is the one held before this sample is folded in; the
  // tracker and the corrected sample both update on the same DCB edge.
  assign dcb_sample = BITSIZE'(sat_to_width(64'(in_q) - 64'(dc_y), BITSIZE));
`endif

  always_comb begin
    // NOTE: every combinational output gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_IDLE:    if (frame_start) state_nxt = ST_CAPTURE;
`ifdef AM_DEMODULATOR_DCBLOCK_EN
      ST_CAPTURE: state_nxt = ST_DCB;
`else
      ST_CAPTURE: state_nxt = ST_RECT;
`endif
      ST_DCB:     state_nxt = ST_RECT;
      ST_RECT:    state_nxt = ST_FILT;
      ST_FILT:    state_nxt = ST_OFFS;
      ST_OFFS:    state_nxt = ST_SCALE;
      ST_SCALE:   state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    // |in|: the most negative code saturates instead of wrapping back.
    rect   = in_q[BITSIZE-1] ? BITSIZE'(sat_to_width(-64'(in_q), BITSIZE)) : in_q;
    offs   = BITSIZE'(sat_to_width(64'(env_y) - 64'(b_q), BITSIZE));
    prod   = (2*BITSIZE)'(d_q) * (2*BITSIZE)'(gain_q);
    scaled = BITSIZE'(sat_to_width(64'(prod >>> (BITSIZE - 1)), BITSIZE));
  end

  // NOTE: the datapath registers are reset along with the control so that
  // out reads 0 straight after reset and no stale frame can leak through.
  always_ff @(posedge bclk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      lr_q      <= 1'b0;
      primed    <= 1'b0;
      in_q      <= '0;
      b_q       <= '0;
      gain_q    <= '0;
      r_q       <= '0;
      d_q       <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      lr_q      <= bus.lrclk;
      primed    <= 1'b1;
      state     <= state_nxt;
      valid_q   <= 1'b0;
      // A frame start while busy is dropped; the current frame carries on.
      overrun_q <= frame_start && (state != ST_IDLE);
      case (state)
        ST_CAPTURE: begin
          in_q   <= bus.in;
          b_q    <= bus.b;
          gain_q <= bus.gain;
        end
`ifdef AM_DEMODULATOR_DCBLOCK_EN
        ST_DCB:   in_q <= dcb_sample;
`endif
        ST_RECT:  r_q <= rect;
        ST_OFFS:  d_q <= offs;
        ST_SCALE: begin
          out_q   <= scaled;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out     = out_q;
  assign bus.valid   = valid_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_am_demodulator.sv
// tb_am_demodulator: directed bench for am_demodulator (BITSIZE=16, SHIFT=4,
// default build). Frames are 32 bclk long; lrclk is high for the first 16.
module tb_am_demodulator;

  logic bclk;
  logic resetn;
  int   checks;
  int   errors;

  am_demodulator_if #(.BITSIZE(16)) bus ();

  am_demodulator #(.BITSIZE(16), .SHIFT(4)) dut (
    .bclk   (bclk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 bclk = ~bclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One 32-cycle frame starting #1 after a rising edge with lrclk low.
  // Iteration i samples #1 after edge E0+i.
  task automatic run_frame(input logic [15:0] s_in, input logic [15:0] s_b,
                           input logic [15:0] s_gain, output int n_valid,
                           output int n_over, output logic [15:0] o_out);
    n_valid   = 0;
    n_over    = 0;
    o_out     = bus.out;
    bus.in    = s_in;
    bus.b     = s_b;
    bus.gain  = s_gain;
    bus.lrclk = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(posedge bclk); #1;
      if (i == 15) bus.lrclk = 1'b0;
      if (bus.valid) begin
        n_valid++;
        o_out = bus.out;
      end
      if (bus.overrun) n_over++;
    end
  endtask

  initial begin
    int          nv, no, bad, neg, nonmono;
    logic [15:0] o, prev;

    checks    = 0;
    errors    = 0;
    bclk      = 1'b0;
    resetn    = 1'b0;
    bus.lrclk = 1'b0;
    bus.in    = '0;
    bus.b     = '0;
    bus.gain  = '0;

    // Reset state.
    #1;
    check("reset_out", bus.out, 16'd0);
    check("reset_valid", bus.valid, 1'b0);
    check("reset_overrun", bus.overrun, 1'b0);
    repeat (3) @(posedge bclk);
    #1 resetn = 1'b1;
    repeat (4) begin @(posedge bclk); #1; end

    // First frame with latency: valid exactly at E0+5, out 1023, y 1024.
    bus.in    = 16'd16384;
    bus.b     = 16'd0;
    bus.gain  = 16'h7fff;
    bus.lrclk = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(posedge bclk); #1;
      if (i == 15) bus.lrclk = 1'b0;
      if (i == 4) check("first_valid_e4", bus.valid, 1'b0);
      if (i == 5) begin
        check("first_valid_e5", bus.valid, 1'b1);
        check("first_out", bus.out, 16'd1023);
        check("first_y", dut.u_env.y, 16'd1024);
      end
      if (i == 6) begin
        check("first_valid_e6", bus.valid, 1'b0);
        check("first_out_held", bus.out, 16'd1023);
      end
    end

    // Convergence: 199 more frames of the same stimulus.
    bad = 0; nonmono = 0; prev = 16'd1023;
    for (int f = 0; f < 199; f++) begin
      run_frame(16'd16384, 16'd0, 16'h7fff, nv, no, o);
      if (nv != 1 || no != 0) bad++;
      if ($signed(o) < $signed(prev)) nonmono++;
      prev = o;
    end
    check("conv_one_valid_per_frame", bad, 0);
    check("conv_monotonic", nonmono, 0);
    check("conv_within_16", ($signed(prev) >= 16352 && $signed(prev) <= 16384), 1'b1);

    // Rectify edge: most negative input, y climbs toward 32767 without wrap.
    bad = 0; nonmono = 0; neg = 0;
    for (int f = 0; f < 200; f++) begin
      run_frame(16'h8000, 16'd0, 16'h7fff, nv, no, o);
      if (nv != 1) bad++;
      if (o[15]) neg++;
      if ($signed(o) < $signed(prev)) nonmono++;
      prev = o;
    end
    check("rect_one_valid_per_frame", bad, 0);
    check("rect_never_negative", neg, 0);
    check("rect_monotonic", nonmono, 0);
    check("rect_out_settled", ($signed(prev) >= 32736), 1'b1);
    check("rect_y_no_wrap", ($signed(dut.u_env.y) >= 32736), 1'b1);

    // Offset saturation: y - b clamps to 32767, scaled by 32767 -> 32766.
    run_frame(16'h8000, 16'h8000, 16'h7fff, nv, no, o);
    check("offs_sat_valid", nv, 1);
    check("offs_sat_out", o, 16'd32766);

    // Reset mid-frame: outputs clear at once, aborted frame never completes.
    bus.in    = 16'd16384;
    bus.b     = 16'd0;
    bus.gain  = 16'h7fff;
    bus.lrclk = 1'b1;
    repeat (2) begin @(posedge bclk); #1; end
    resetn = 1'b0;
    #1;
    check("midreset_out", bus.out, 16'd0);
    check("midreset_valid", bus.valid, 1'b0);
    check("midreset_overrun", bus.overrun, 1'b0);
    check("midreset_y", dut.u_env.y, 16'd0);
    @(posedge bclk); #1;
    resetn = 1'b1;
    nv = 0;
    for (int i = 0; i < 28; i++) begin
      @(posedge bclk); #1;
      if (i == 12) bus.lrclk = 1'b0;
      if (bus.valid) nv++;
    end
    check("midreset_no_valid", nv, 0);

    // Negative-gain clamp: y=0, b=32767, gain=-32768 -> 32767.
    run_frame(16'd0, 16'h7fff, 16'h8000, nv, no, o);
    check("neg_gain_valid", nv, 1);
    check("neg_gain_out", o, 16'd32767);
    check("neg_gain_y", dut.u_env.y, 16'd0);

    // Overrun: second lrclk rise 3 bclk after the first.
    bus.in    = 16'd16384;
    bus.b     = 16'd0;
    bus.gain  = 16'h7fff;
    bus.lrclk = 1'b1;
    nv = 0; no = 0; o = 16'd0;
    for (int i = 0; i < 32; i++) begin
      @(posedge bclk); #1;
      if (i == 0) bus.lrclk = 1'b0;
      if (i == 2) bus.lrclk = 1'b1;
      if (i == 15) bus.lrclk = 1'b0;
      if (bus.valid) begin nv++; o = bus.out; end
      if (bus.overrun) no++;
    end
    check("overrun_pulses", no, 1);
    check("overrun_valids", nv, 1);
    check("overrun_out", o, 16'd1023);
    check("overrun_y_once", dut.u_env.y, 16'd1024);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
